// File: rtl/mainfsm.sv
// mainfsm: multicycle ARM control sequencer.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// produces the unconditioned enables (NextPC, RegW, MemW) plus the datapath
// mux selects. Memory accesses in FETCH, MEMRD and MEMWR wait on MemReady.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    // Only I (Funct[5]) and L (Funct[0]) steer the sequence.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    assign State = state_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; Op/Funct are only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
            MEMWR:   state_d = MemReady ? FETCH : MEMWR;
            MEMWB:   state_d = FETCH;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; FETCH enables also wait for MemReady and are
    // held off while reset is low.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = MemReady & reset;
                NextPC    = MemReady & reset;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                // PC+8 lands on R15 reads during decode.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            EXECR: begin
                ALUOp     = 1'b1;
            end
            EXECI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            ALUWB: begin
                RegW      = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
                RegW      = 1'b0;
            end
        endcase
    end

endmodule
